// File: rtl/wb_pkg.sv
// Package: wb_pkg
// Shared definitions for the writeback stage.
//   - Load-op encodings on wb_load_op_i (LD_W, LD_H, LD_HU, LD_B, LD_BU)
//   - Skid FIFO depth
//   - Datapath widths and the FIFO entry struct {dest, data}
// Optional feature macro used by writeback_stage: WB_FORWARD_EN
package wb_pkg;

    localparam int WB_DW         = 32;
    localparam int WB_AW         = 5;
    localparam int WB_FIFO_DEPTH = 2;

    // Codes 101..111 are not listed here and decode as a full word load.
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } load_op_e;

    typedef struct packed {
        logic [WB_AW-1:0] dest;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Module: wb_load_align
// Combinational little-endian load extraction and extension.
// Ports:
//   op        in  3   load type (wb_pkg load_op_e encodings)
//   byte_off  in  2   address bits [1:0] of the load
//   word      in  DW  raw memory word
//   data      out DW  aligned, extended load result
// Halves are selected by byte_off[1] only; byte_off[0] is ignored for them.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DW = WB_DW
) (
    input  logic [2:0]    op,
    input  logic [1:0]    byte_off,
    input  logic [DW-1:0] word,
    output logic [DW-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
        data     = word;
        case (op)
            LD_H:    data = {{(DW-16){half_sel[15]}}, half_sel};
            LD_HU:   data = {{(DW-16){1'b0}}, half_sel};
            LD_B:    data = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_BU:   data = {{(DW-8){1'b0}}, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Module: writeback_stage
// Writeback stage owning the register file's single write port.
// Completed results arrive over a valid/ready handshake, have their final
// data selected (ALU result or aligned load) before buffering, and sit in a
// 2-entry skid FIFO until the write port is free. A debug write channel has
// priority over the FIFO head. Register 0 is never written.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   wb_valid_i / wb_ready_o     upstream handshake (ready = count < 2)
//   wb_reg_write_i              entry writes a register (else dropped)
//   wb_mem_to_reg_i             1 = load data, 0 = ALU result
//   wb_load_op_i, wb_byte_off_i load type and address bits [1:0]
//   wb_dest_i, wb_alu_result_i, wb_mem_data_i   entry payload
//   dbg_we_i, dbg_addr_i, dbg_data_i            priority debug write
//   Reg_Write_o, Write_Register_o, Write_Data_o register file write port
//   retire_cnt_o                committed non-debug writes (wrapping)
// Optional: WB_FORWARD_EN adds fwd_valid_o / fwd_dest_o / fwd_data_o,
//   a copy of this cycle's port write for same-cycle decode bypass.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid_i,
    output logic          wb_ready_o,
    input  logic          wb_reg_write_i,
    input  logic          wb_mem_to_reg_i,
    input  logic [2:0]    wb_load_op_i,
    input  logic [1:0]    wb_byte_off_i,
    input  logic [AW-1:0] wb_dest_i,
    input  logic [DW-1:0] wb_alu_result_i,
    input  logic [DW-1:0] wb_mem_data_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_data_i,
    output logic          Reg_Write_o,
    output logic [AW-1:0] Write_Register_o,
    output logic [DW-1:0] Write_Data_o,
    output logic [31:0]   retire_cnt_o
`ifdef WB_FORWARD_EN
    ,
    output logic          fwd_valid_o,
    output logic [AW-1:0] fwd_dest_o,
    output logic [DW-1:0] fwd_data_o
`endif
);

    // FIFO storage and pointers (depth 2: single-bit pointers, 2-bit count)
    wb_entry_t  fifo_mem [WB_FIFO_DEPTH];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [31:0] retire_cnt_reg;

    logic [DW-1:0] load_data;
    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic          push;
    logic          pop;

    wb_load_align #(.DW(DW)) u_align (
        .op       (wb_load_op_i),
        .byte_off (wb_byte_off_i),
        .word     (wb_mem_data_i),
        .data     (load_data)
    );

    assign wb_ready_o = (count_reg < 2'(WB_FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr_reg];

    always_comb begin
        push_entry.dest = wb_dest_i;
        push_entry.data = wb_mem_to_reg_i ? load_data : wb_alu_result_i;
    end

    // Ready is evaluated on the pre-pop count, so a full FIFO that pops this
    // edge still refuses the incoming entry; the slot opens next cycle.
    // Non-writing instructions are accepted but never occupy a slot.
    assign push = wb_valid_i && wb_ready_o && wb_reg_write_i && !reset;
    // Debug owns the port this cycle, so the head holds.
    assign pop  = !dbg_we_i && (count_reg != 2'd0) && !reset;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            count_reg      <= 2'd0;
            retire_cnt_reg <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                if (head.dest != '0) begin
                    retire_cnt_reg <= retire_cnt_reg + 32'd1;
                end
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign retire_cnt_o = retire_cnt_reg;

    // Write port mux: debug first, then FIFO head. A write to register 0
    // keeps its address/data on the port but never asserts the enable.
    always_comb begin
        Reg_Write_o      = 1'b0;
        Write_Register_o = '0;
        Write_Data_o     = '0;
        if (!reset) begin
            if (dbg_we_i) begin
                Reg_Write_o      = (dbg_addr_i != '0);
                Write_Register_o = dbg_addr_i;
                Write_Data_o     = dbg_data_i;
            end else if (count_reg != 2'd0) begin
                Reg_Write_o      = (head.dest != '0);
                Write_Register_o = head.dest;
                Write_Data_o     = head.data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid_o = Reg_Write_o;
    assign fwd_dest_o  = Write_Register_o;
    assign fwd_data_o  = Write_Data_o;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: table of single-entry transactions followed
// by hand-written debug-priority/backpressure and reset-mid-stream sequences.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic        wb_reg_write_i;
    logic        wb_mem_to_reg_i;
    logic [2:0]  wb_load_op_i;
    logic [1:0]  wb_byte_off_i;
    logic [4:0]  wb_dest_i;
    logic [31:0] wb_alu_result_i;
    logic [31:0] wb_mem_data_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_i;
    logic        Reg_Write_o;
    logic [4:0]  Write_Register_o;
    logic [31:0] Write_Data_o;
    logic [31:0] retire_cnt_o;
`ifdef WB_FORWARD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_dest_o;
    logic [31:0] fwd_data_o;
`endif

    writeback_stage dut (
        .clk              (clk),
        .reset            (reset),
        .wb_valid_i       (wb_valid_i),
        .wb_ready_o       (wb_ready_o),
        .wb_reg_write_i   (wb_reg_write_i),
        .wb_mem_to_reg_i  (wb_mem_to_reg_i),
        .wb_load_op_i     (wb_load_op_i),
        .wb_byte_off_i    (wb_byte_off_i),
        .wb_dest_i        (wb_dest_i),
        .wb_alu_result_i  (wb_alu_result_i),
        .wb_mem_data_i    (wb_mem_data_i),
        .dbg_we_i         (dbg_we_i),
        .dbg_addr_i       (dbg_addr_i),
        .dbg_data_i       (dbg_data_i),
        .Reg_Write_o      (Reg_Write_o),
        .Write_Register_o (Write_Register_o),
        .Write_Data_o     (Write_Data_o),
        .retire_cnt_o     (retire_cnt_o)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid_o      (fwd_valid_o),
        .fwd_dest_o       (fwd_dest_o),
        .fwd_data_o       (fwd_data_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        reg_write;
        logic        mem_to_reg;
        logic [2:0]  op;
        logic [1:0]  off;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_retire = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] rd,
                              input logic [31:0] data);
        check({tag, ".we"}, 32'(Reg_Write_o), 32'(we));
        if (we) begin
            check({tag, ".reg"}, 32'(Write_Register_o), 32'(rd));
            check({tag, ".data"}, Write_Data_o, data);
`ifdef WB_FORWARD_EN
            check({tag, ".fwd_valid"}, 32'(fwd_valid_o), 32'd1);
            check({tag, ".fwd_dest"}, 32'(fwd_dest_o), 32'(rd));
            check({tag, ".fwd_data"}, fwd_data_o, data);
`endif
        end
    endtask

    task automatic drive(input logic valid, input logic [4:0] dest, input logic [31:0] alu);
        wb_valid_i      = valid;
        wb_reg_write_i  = 1'b1;
        wb_mem_to_reg_i = 1'b0;
        wb_load_op_i    = 3'b000;
        wb_byte_off_i   = 2'b00;
        wb_dest_i       = dest;
        wb_alu_result_i = alu;
        wb_mem_data_i   = 32'h0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"alu14",   1, 0, 3'b000, 2'd0, 5'd14, 32'hFEDCAB98, 32'h11111111, 1, 32'hFEDCAB98};
        vecs[1] = '{"lb_off0", 1, 1, 3'b011, 2'd0, 5'd1,  32'h0,        32'h89ABCDEF, 1, 32'hFFFFFFEF};
        vecs[2] = '{"lbu_off2",1, 1, 3'b100, 2'd2, 5'd2,  32'h0,        32'h89ABCDEF, 1, 32'h000000AB};
        vecs[3] = '{"lh_off2", 1, 1, 3'b001, 2'd2, 5'd3,  32'h0,        32'h89ABCDEF, 1, 32'hFFFF89AB};
        vecs[4] = '{"lhu_off0",1, 1, 3'b010, 2'd0, 5'd4,  32'h0,        32'h89ABCDEF, 1, 32'h0000CDEF};
        vecs[5] = '{"op111",   1, 1, 3'b111, 2'd3, 5'd5,  32'h0,        32'h89ABCDEF, 1, 32'h89ABCDEF};
        vecs[6] = '{"lh_off3", 1, 1, 3'b001, 2'd3, 5'd6,  32'h0,        32'h12348765, 1, 32'h00001234};
        vecs[7] = '{"lb_off3", 1, 1, 3'b011, 2'd3, 5'd31, 32'h0,        32'h80FF0000, 1, 32'hFFFFFF80};
        vecs[8] = '{"dest0",   1, 0, 3'b000, 2'd0, 5'd0,  32'h12345678, 32'h0,        0, 32'h12345678};
        vecs[9] = '{"no_wr",   0, 0, 3'b000, 2'd0, 5'd9,  32'hCAFEF00D, 32'h0,        0, 32'hCAFEF00D};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0);
        dbg_we_i   = 1'b0;
        dbg_addr_i = 5'd0;
        dbg_data_i = 32'h0;
        #12;
        check("rst.we", 32'(Reg_Write_o), 32'd0);
        check("rst.reg", 32'(Write_Register_o), 32'd0);
        check("rst.data", Write_Data_o, 32'd0);
        check("rst.retire", retire_cnt_o, 32'd0);
        check("rst.ready", 32'(wb_ready_o), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single-entry transactions through an empty FIFO.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            wb_valid_i      = 1'b1;
            wb_reg_write_i  = vecs[i].reg_write;
            wb_mem_to_reg_i = vecs[i].mem_to_reg;
            wb_load_op_i    = vecs[i].op;
            wb_byte_off_i   = vecs[i].off;
            wb_dest_i       = vecs[i].dest;
            wb_alu_result_i = vecs[i].alu;
            wb_mem_data_i   = vecs[i].mem;
            @(posedge clk); #1;
            wb_valid_i = 1'b0;
            #1;
            check_port(vecs[i].name, vecs[i].exp_we, vecs[i].dest, vecs[i].exp_data);
            check({vecs[i].name, ".ready"}, 32'(wb_ready_o), 32'd1);
            if (vecs[i].reg_write && vecs[i].dest != 5'd0) exp_retire++;
            @(posedge clk); #2;
            check({vecs[i].name, ".idle_we"}, 32'(Reg_Write_o), 32'd0);
            check({vecs[i].name, ".retire"}, retire_cnt_o, exp_retire);
        end

        // Debug write to register 0 is suppressed.
        @(posedge clk); #1;
        dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_data_i = 32'hDEAD0000;
        #1;
        check("dbg0.we", 32'(Reg_Write_o), 32'd0);
        @(posedge clk); #1;
        dbg_we_i = 1'b0;

        // Debug held three cycles while three results arrive.
        @(posedge clk); #1;
        dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_data_i = 32'hD0D00001;
        drive(1'b1, 5'd10, 32'hAAAA0001);
        #1;
        check_port("dbg.c0", 1'b1, 5'd7, 32'hD0D00001);
        check("dbg.c0.ready", 32'(wb_ready_o), 32'd1);
        @(posedge clk); #1;
        dbg_data_i = 32'hD0D00002;
        drive(1'b1, 5'd11, 32'hBBBB0002);
        #1;
        check_port("dbg.c1", 1'b1, 5'd7, 32'hD0D00002);
        check("dbg.c1.ready", 32'(wb_ready_o), 32'd1);
        @(posedge clk); #1;
        dbg_data_i = 32'hD0D00003;
        drive(1'b1, 5'd12, 32'hCCCC0003);
        #1;
        check_port("dbg.c2", 1'b1, 5'd7, 32'hD0D00003);
        check("dbg.c2.ready", 32'(wb_ready_o), 32'd0);
        @(posedge clk); #1;
        dbg_we_i = 1'b0;
        #1;
        check_port("drain.a", 1'b1, 5'd10, 32'hAAAA0001);
        check("drain.a.ready", 32'(wb_ready_o), 32'd0);
        @(posedge clk); #2;
        check_port("drain.b", 1'b1, 5'd11, 32'hBBBB0002);
        check("drain.b.ready", 32'(wb_ready_o), 32'd1);
        check("drain.b.retire", retire_cnt_o, exp_retire + 32'd1);
        @(posedge clk); #1;
        wb_valid_i = 1'b0;
        #1;
        check_port("drain.c", 1'b1, 5'd12, 32'hCCCC0003);
        check("drain.c.ready", 32'(wb_ready_o), 32'd1);
        @(posedge clk); #2;
        exp_retire += 32'd3;
        check("drain.idle_we", 32'(Reg_Write_o), 32'd0);
        check("drain.retire", retire_cnt_o, exp_retire);

        // Reset with two entries buffered behind a debug write.
        @(posedge clk); #1;
        dbg_we_i = 1'b1; dbg_addr_i = 5'd8; dbg_data_i = 32'h0BAD0BAD;
        drive(1'b1, 5'd20, 32'h20202020);
        @(posedge clk); #1;
        drive(1'b1, 5'd21, 32'h21212121);
        @(posedge clk); #1;
        wb_valid_i = 1'b0;
        #1;
        check("full.ready", 32'(wb_ready_o), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst.we", 32'(Reg_Write_o), 32'd0);
        check("mid_rst.reg", 32'(Write_Register_o), 32'd0);
        check("mid_rst.data", Write_Data_o, 32'd0);
        check("mid_rst.retire", retire_cnt_o, 32'd0);
        check("mid_rst.ready", 32'(wb_ready_o), 32'd1);
        dbg_we_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst.we", 32'(Reg_Write_o), 32'd0);
        @(posedge clk); #2;
        check("post_rst.we2", 32'(Reg_Write_o), 32'd0);
        check("post_rst.retire", retire_cnt_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
